// File: rtl/egress_frame_sink.sv
// Egress frame sink: 2-entry skid FIFO with framing FSM, frame length report and status counters.
// Optional stall watchdog enabled by defining EGRESS_FRAME_SINK_WDOG_EN.
//
// state    | meaning
// IDLE     | between frames; a beat without sop is dropped as an orphan
// IN_FRAME | sop seen, forwarding beats until eop
module egress_frame_sink #(
  parameter int DATA_W     = 40,
  parameter int LEN_W      = 16,
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              frame_len_valid,
  output logic [LEN_W-1:0]  frame_len,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  orphan_cnt,
  output logic [CNT_W-1:0]  nested_cnt,
  output logic              wdog_timeout,
  output logic              wdog_sticky
);

  typedef enum logic {IDLE = 1'b0, IN_FRAME = 1'b1} state_t;

  localparam int ENT_W = DATA_W + 2;

  state_t           state;
  logic [ENT_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic             acc;
  logic             fwd;
  logic             push;
  logic             pop;
  logic [LEN_W-1:0] len_cnt;
  logic [LEN_W-1:0] len_nxt;
  logic             wdog_fire;

  assign acc  = in_valid & in_ready;
  assign fwd  = in_sop | (state == IN_FRAME);
  assign push = acc & fwd;
  assign pop  = out_valid & out_ready;

  assign out_valid = (count != 2'd0);
  assign out_sop   = mem[rd_ptr][ENT_W-1];
  assign out_eop   = mem[rd_ptr][ENT_W-2];
  assign out_data  = mem[rd_ptr][DATA_W-1:0];

  always_comb begin
    count_nxt = count + {1'b0, push} - {1'b0, pop};
  end

  // A sop beat always restarts the count, including a nested sop.
  always_comb begin
    len_nxt = len_cnt;
    if (in_sop)
      len_nxt = LEN_W'(1);
    else if (len_cnt != {LEN_W{1'b1}})
      len_nxt = len_cnt + LEN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_sop, in_eop, in_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count    <= count_nxt;
      in_ready <= (count_nxt < 2'd2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      len_cnt         <= '0;
      frame_len_valid <= 1'b0;
      frame_len       <= '0;
      frame_cnt       <= '0;
      orphan_cnt      <= '0;
      nested_cnt      <= '0;
    end else begin
      frame_len_valid <= 1'b0;
      if (wdog_fire) begin
        state   <= IDLE;
        len_cnt <= '0;
      end else if (acc) begin
        if (!fwd) begin
          if (orphan_cnt != {CNT_W{1'b1}})
            orphan_cnt <= orphan_cnt + CNT_W'(1);
        end else begin
          if (state == IN_FRAME && in_sop && nested_cnt != {CNT_W{1'b1}})
            nested_cnt <= nested_cnt + CNT_W'(1);
          if (in_eop) begin
            frame_len_valid <= 1'b1;
            frame_len       <= len_nxt;
            if (frame_cnt != {CNT_W{1'b1}})
              frame_cnt <= frame_cnt + CNT_W'(1);
            state   <= IDLE;
            len_cnt <= '0;
          end else begin
            state   <= IN_FRAME;
            len_cnt <= len_nxt;
          end
        end
      end
    end
  end

`ifdef EGRESS_FRAME_SINK_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);

  logic [WD_W-1:0] wdog_cnt;

  // Fires on the cycle that would bring the idle count up to WDOG_LIMIT.
  assign wdog_fire = (state == IN_FRAME) && !acc && (wdog_cnt == WD_W'(WDOG_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt     <= '0;
      wdog_timeout <= 1'b0;
      wdog_sticky  <= 1'b0;
    end else begin
      wdog_timeout <= wdog_fire;
      if (wdog_fire)
        wdog_sticky <= 1'b1;
      if (state != IN_FRAME || acc || wdog_fire)
        wdog_cnt <= '0;
      else
        wdog_cnt <= wdog_cnt + WD_W'(1);
    end
  end
`else
  assign wdog_fire    = 1'b0;
  assign wdog_timeout = 1'b0;
  assign wdog_sticky  = 1'b0;
`endif

endmodule

// File: doc/egress_frame_sink.md
EGRESS_FRAME_SINK -- requirements
Module: egress_frame_sink

Interface
REQ-001 Parameter DATA_W, default 40, sets the width of the egress data word.
REQ-002 Parameter LEN_W, default 16, sets the width of the frame length report.
REQ-003 Parameter CNT_W, default 16, sets the width of each status counter.
REQ-004 Parameter WDOG_LIMIT, default 1024, sets the stall-watchdog threshold in cycles.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Ports in_valid, in_sop and in_eop are 1-bit inputs, and in_data is a DATA_W-bit input; they carry the frame-table egress beat.
REQ-009 Port in_ready, output, 1 bit: egress backpressure to the frame table; it SHALL be driven directly from a flop.
REQ-010 Ports out_valid, out_sop and out_eop are 1-bit outputs, and out_data is a DATA_W-bit output; they carry the downstream beat.
REQ-011 Port out_ready, input, 1 bit: downstream backpressure.
REQ-012 Ports frame_len_valid (1-bit output) and frame_len (LEN_W-bit output) report the length of each completed frame.
REQ-013 Ports frame_cnt, orphan_cnt and nested_cnt are CNT_W-bit outputs: completed frames, dropped orphan beats, and nested SOPs.
REQ-014 Ports wdog_timeout (1-bit pulse) and wdog_sticky (1-bit level) report stall-watchdog events.

Function
REQ-015 Buffering SHALL use a 2-entry skid FIFO; in_ready is registered high when the next occupancy is below 2.
REQ-016 A beat is accepted when in_valid and in_ready are both high; a forwarded beat appears on out_* exactly 1 cycle after acceptance if the FIFO was empty.
REQ-017 out_* SHALL hold stable while out_valid is high and out_ready is low; the FIFO pops on out_valid and out_ready; a simultaneous push and pop keeps occupancy unchanged.
REQ-018 The framing FSM SHALL have states IDLE and IN_FRAME.
REQ-019 In IDLE, an accepted beat with sop=1 goes to IN_FRAME, or stays in IDLE when eop=1 (single-beat frame).
REQ-020 In IDLE, an accepted beat with sop=0 is an orphan: it is consumed, not forwarded, orphan_cnt increments, and the state stays IDLE.
REQ-021 In IN_FRAME, an accepted beat with sop=1 increments nested_cnt, is forwarded unchanged, and restarts the length count at 1.
REQ-022 In IN_FRAME, an accepted beat with eop=1 returns the FSM to IDLE.
REQ-023 The length counter SHALL count accepted forwarded beats including the SOP and EOP beats, and saturate at 2^LEN_W-1.
REQ-024 On EOP acceptance, frame_len_valid SHALL pulse for 1 cycle, 1 cycle later, with frame_len set to the count; frame_cnt increments at the same time.
REQ-025 frame_len SHALL hold its value between pulses.
REQ-026 All three status counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-027 While rst_n is low, all outputs SHALL be 0: in_ready, out_valid, frame_len_valid, frame_len, all counters, wdog_timeout and wdog_sticky.
REQ-028 While rst_n is low, the FIFO SHALL be empty and the FSM SHALL be in IDLE.
REQ-029 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-030 A reset asserted mid-frame SHALL discard buffered beats and the partial length with no frame_len_valid pulse.

Configuration
REQ-031 Macro EGRESS_FRAME_SINK_WDOG_EN, when defined, SHALL count consecutive cycles spent in IN_FRAME with no accepted beat.
REQ-032 With the macro defined, reaching WDOG_LIMIT SHALL pulse wdog_timeout for 1 cycle, set wdog_sticky (cleared only by reset), and force the FSM to IDLE with the length discarded.
REQ-033 With the macro defined, any accepted beat SHALL clear the watchdog count.
REQ-034 Without the macro, wdog_timeout and wdog_sticky SHALL be tied to 0 and no watchdog counter SHALL be synthesized.

Verification
REQ-035 A 4-beat frame (sop on beat 0, eop on beat 3) with out_ready=1 SHALL produce 4 out beats, frame_len=4 pulsed once, and frame_cnt=1.
REQ-036 A single beat with sop=1 and eop=1 SHALL produce frame_len=1, frame_cnt=1, and the FSM SHALL stay in IDLE.
REQ-037 Two beats with sop=0 sent while in IDLE SHALL produce orphan_cnt=2 and no out_valid.
REQ-038 A frame sent with out_ready=0 SHALL drop in_ready after 2 accepts; releasing out_ready SHALL drain the beats in order with no loss or duplicate.
REQ-039 The sequence sop, data, sop, data, eop SHALL produce nested_cnt=1, frame_len=3, and frame_cnt=1.
REQ-040 With the macro defined and WDOG_LIMIT=8, a SOP followed by 8 idle cycles SHALL pulse wdog_timeout once and set wdog_sticky=1; the next sop=0 beat SHALL be counted as an orphan.
